// File: rtl/wm_pkg.sv
// Shared state/clock-rate encodings and default phase durations.
// Optional build macro: WASHING_MACHINE_PAUSE_ANY_EN (see top module).
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5
    } wm_state_e;

    localparam logic [1:0] FREQ_1X = 2'b00;
    localparam logic [1:0] FREQ_2X = 2'b01;
    localparam logic [1:0] FREQ_4X = 2'b10;
    localparam logic [1:0] FREQ_8X = 2'b11;

    localparam int DEF_CLK_BASE_HZ = 1000000;
    localparam int DEF_FILL_S      = 120;
    localparam int DEF_WASH_S      = 300;
    localparam int DEF_RINSE_S     = 120;
    localparam int DEF_SPIN_S      = 60;
    localparam int DEF_MAX_WASHES  = 4;

    function automatic int max_phase_s(input int a, input int b,
                                       input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/wm_sec_prescaler.sv
// One-second tick generator scaled by the runtime clock-rate select.
// A rate change restarts the count; hold freezes it.
module wm_sec_prescaler
    import wm_pkg::*;
#(
    parameter int CLK_BASE_HZ = DEF_CLK_BASE_HZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] clk_freq,
    input  logic       hold,
    output logic       sec_tick
);

    localparam int CNT_W = $clog2(CLK_BASE_HZ * 8);

    logic [CNT_W-1:0] cnt_q, cnt_d, limit;
    logic [1:0]       freq_q, freq_d;

    always_comb begin
        case (clk_freq)
            FREQ_1X: limit = CNT_W'(CLK_BASE_HZ - 1);
            FREQ_2X: limit = CNT_W'(CLK_BASE_HZ * 2 - 1);
            FREQ_4X: limit = CNT_W'(CLK_BASE_HZ * 4 - 1);
            FREQ_8X: limit = CNT_W'(CLK_BASE_HZ * 8 - 1);
            default: limit = CNT_W'(CLK_BASE_HZ - 1);
        endcase
        freq_d   = clk_freq;
        sec_tick = !hold && (clk_freq == freq_q) && (cnt_q == limit);
        cnt_d    = cnt_q;
        if (clk_freq != freq_q)
            cnt_d = '0;
        else if (!hold)
            cnt_d = sec_tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            freq_q <= freq_d;
        end else begin
            cnt_q  <= cnt_d;
            freq_q <= freq_d;
        end
    end

endmodule

// File: rtl/washing_machine_ctrl_param.sv
// Coin-started FILL/WASH/RINSE(xN)/SPIN/DONE controller with real-second timing.
// Define WASHING_MACHINE_PAUSE_ANY_EN to honour timer_pause in every busy phase.
module washing_machine_ctrl_param
    import wm_pkg::*;
#(
    parameter int CLK_BASE_HZ = DEF_CLK_BASE_HZ,
    parameter int FILL_S      = DEF_FILL_S,
    parameter int WASH_S      = DEF_WASH_S,
    parameter int RINSE_S     = DEF_RINSE_S,
    parameter int SPIN_S      = DEF_SPIN_S,
    parameter int MAX_WASHES  = DEF_MAX_WASHES,
    parameter int WC_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      clk_freq,
    input  logic            coin_in,
    input  logic [WC_W-1:0] wash_count,
    input  logic            timer_pause,
    output logic            wash_done,
    output logic [2:0]      phase,
    output logic            busy,
    output logic [WC_W-1:0] washes_left
);

    localparam int MAX_S = max_phase_s(FILL_S, WASH_S, RINSE_S, SPIN_S);
    localparam int SEC_W = (MAX_S > 1) ? $clog2(MAX_S) : 1;

    wm_state_e        state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d, phase_last;
    logic [WC_W-1:0]  left_q, left_d;
    logic             coin_q, coin_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             start, hold, sec_tick;

    assign coin_d = coin_in;
    assign start  = coin_in && !coin_q &&
                    (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef WASHING_MACHINE_PAUSE_ANY_EN
    assign hold = timer_pause && (state_q inside {ST_FILL, ST_WASH,
                                                  ST_RINSE, ST_SPIN});
`else
    assign hold = timer_pause && (state_q == ST_SPIN);
`endif

    // Restarting on the accepted coin aligns the first second to FILL entry.
    wm_sec_prescaler #(
        .CLK_BASE_HZ(CLK_BASE_HZ)
    ) u_presc (
        .clk      (clk),
        .rst      (rst || start),
        .clk_freq (clk_freq),
        .hold     (hold),
        .sec_tick (sec_tick)
    );

    always_comb begin
        case (state_q)
            ST_FILL:  phase_last = SEC_W'(FILL_S - 1);
            ST_WASH:  phase_last = SEC_W'(WASH_S - 1);
            ST_RINSE: phase_last = SEC_W'(RINSE_S - 1);
            ST_SPIN:  phase_last = SEC_W'(SPIN_S - 1);
            default:  phase_last = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        left_d  = left_q;
        if (start) begin
            state_d = ST_FILL;
            sec_d   = '0;
            if (wash_count == '0)
                left_d = WC_W'(1);
            else if (wash_count > WC_W'(MAX_WASHES))
                left_d = WC_W'(MAX_WASHES);
            else
                left_d = wash_count;
        end else if (sec_tick && state_q inside {ST_FILL, ST_WASH,
                                                 ST_RINSE, ST_SPIN}) begin
            if (sec_q != phase_last) begin
                sec_d = sec_q + SEC_W'(1);
            end else begin
                sec_d = '0;
                case (state_q)
                    ST_FILL: state_d = ST_WASH;
                    ST_WASH: state_d = ST_RINSE;
                    ST_RINSE: begin
                        if (left_q > WC_W'(1)) begin
                            left_d  = left_q - WC_W'(1);
                            state_d = ST_WASH;
                        end else begin
                            state_d = ST_SPIN;
                        end
                    end
                    default: begin
                        state_d = ST_DONE;
                        left_d  = '0;
                    end
                endcase
            end
        end
        done_d = (state_d == ST_DONE);
        busy_d = state_d inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            left_q  <= '0;
            coin_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            left_q  <= left_d;
            coin_q  <= coin_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign phase       = state_q;
    assign wash_done   = done_q;
    assign busy        = busy_q;
    assign washes_left = left_q;

endmodule

// File: tb/tb_washing_machine_ctrl_param.sv
// Self-checking bench for washing_machine_ctrl_param with small phase lengths.
// Honours WASHING_MACHINE_PAUSE_ANY_EN when computing the WASH-pause delay.
module tb_washing_machine_ctrl_param;

    localparam int CB  = 4;
    localparam int FS  = 2;
    localparam int WS  = 3;
    localparam int RS  = 2;
    localparam int SS  = 1;
    localparam int MW  = 4;
    localparam int WCW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     clk_freq = 2'b00;
    logic           coin_in = 1'b0;
    logic [WCW-1:0] wash_count = '0;
    logic           timer_pause = 1'b0;
    logic           wash_done;
    logic [2:0]     phase;
    logic           busy;
    logic [WCW-1:0] washes_left;

    washing_machine_ctrl_param #(
        .CLK_BASE_HZ(CB), .FILL_S(FS), .WASH_S(WS), .RINSE_S(RS),
        .SPIN_S(SS), .MAX_WASHES(MW), .WC_W(WCW)
    ) dut (
        .clk(clk), .rst(rst), .clk_freq(clk_freq), .coin_in(coin_in),
        .wash_count(wash_count), .timer_pause(timer_pause),
        .wash_done(wash_done), .phase(phase), .busy(busy),
        .washes_left(washes_left)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]     ph;
        logic [WCW-1:0] left;
    } exp_t;

    typedef struct {
        logic [1:0]     f;
        logic [WCW-1:0] wc;
        logic [2:0]     pst;
        int             plen;
        bit             repulse;
        int             passes;
        int             extra;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_seq(input int n);
        exp_t e;
        e.ph = 3'd1; e.left = WCW'(n); sb.push_back(e);
        for (int k = n; k >= 1; k--) begin
            e.ph = 3'd2; e.left = WCW'(k); sb.push_back(e);
            e.ph = 3'd3; e.left = WCW'(k); sb.push_back(e);
        end
        e.ph = 3'd4; e.left = WCW'(1); sb.push_back(e);
        e.ph = 3'd5; e.left = '0;      sb.push_back(e);
    endtask

    task automatic run(input vec_t v, input bit keep_coin, input string tag);
        int   exp_cyc;
        int   cyc;
        int   pcnt;
        bit   started;
        bit   done;
        bit   rep;
        logic [2:0] last;
        exp_t e;
        exp_cyc = (FS + v.passes * (WS + RS) + SS) * CB * (1 << v.f) + v.extra;
        cyc = 0; pcnt = 0; started = 0; done = 0; rep = 0;
        coin_in = 1'b0;
        @(negedge clk);
        last = phase;
        push_seq(v.passes);
        clk_freq   = v.f;
        wash_count = v.wc;
        coin_in    = 1'b1;
        for (int t = 0; t < 6000 && !done; t++) begin
            @(negedge clk);
            if (phase !== last) begin
                if (sb.size() == 0) begin
                    chk({tag, " sb_underflow"}, {29'd0, phase}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " phase"}, {29'd0, phase}, {29'd0, e.ph});
                    chk({tag, " washes_left"}, {29'd0, washes_left},
                        {29'd0, e.left});
                    chk({tag, " busy"}, {31'd0, busy},
                        {31'd0, (e.ph >= 3'd1 && e.ph <= 3'd4)});
                end
                last = phase;
            end
            if (started) cyc++;
            if (!started && phase === 3'd1) started = 1;
            coin_in = keep_coin;
            if (v.repulse && phase === 3'd3 && !rep) begin
                coin_in = 1'b1;
                rep = 1;
            end
            if (v.plen > 0 && phase === v.pst && pcnt < v.plen) begin
                timer_pause = 1'b1;
                pcnt++;
            end else begin
                timer_pause = 1'b0;
            end
            if (wash_done === 1'b1) begin
                done = 1;
                chk({tag, " cycles"}, cyc, exp_cyc);
            end
        end
        timer_pause = 1'b0;
        if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
        chk({tag, " sb_empty"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        int wait_ok;
        vecs[0] = '{2'd0, 3'd1, 3'd0, 0,  1'b0, 1, 0};
        vecs[1] = '{2'd0, 3'd3, 3'd0, 0,  1'b0, 3, 0};
        vecs[2] = '{2'd3, 3'd3, 3'd0, 0,  1'b0, 3, 0};
        vecs[3] = '{2'd0, 3'd0, 3'd0, 0,  1'b0, 1, 0};
        vecs[4] = '{2'd0, 3'd7, 3'd0, 0,  1'b0, 4, 0};
        vecs[5] = '{2'd1, 3'd2, 3'd0, 0,  1'b1, 2, 0};
        vecs[6] = '{2'd0, 3'd1, 3'd4, 20, 1'b0, 1, 20};
`ifdef WASHING_MACHINE_PAUSE_ANY_EN
        vecs[7] = '{2'd0, 3'd1, 3'd2, 20, 1'b0, 1, 20};
`else
        vecs[7] = '{2'd0, 3'd1, 3'd2, 20, 1'b0, 1, 0};
`endif
        vecs[8] = '{2'd2, 3'd1, 3'd0, 0,  1'b1, 1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset phase", {29'd0, phase}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, wash_done}, 32'd0);
        chk("reset left", {29'd0, washes_left}, 32'd0);

        for (int i = 0; i < 9; i++)
            run(vecs[i], 1'b0, $sformatf("vec%0d", i));

        run(vecs[0], 1'b1, "hold_coin");
        repeat (10) @(negedge clk);
        chk("hold no retrigger", {29'd0, phase}, 32'd5);
        coin_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("coin low stays done", {29'd0, phase}, 32'd5);
        run(vecs[0], 1'b0, "restart");

        wash_count = 3'd2;
        coin_in = 1'b1;
        wait_ok = 0;
        for (int t = 0; t < 200 && !wait_ok; t++) begin
            @(negedge clk);
            coin_in = 1'b0;
            if (phase === 3'd2) wait_ok = 1;
        end
        chk("reach wash", wait_ok, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort phase", {29'd0, phase}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, wash_done}, 32'd0);
        chk("abort left", {29'd0, washes_left}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle after abort", {29'd0, phase}, 32'd0);
        run(vecs[1], 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
